// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts one byte + odd parity + stop on device clock falls, then checks the ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int TW = 21;
  localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    EDGE_MAX     = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t          state_reg;
  logic [9:0]      sh_reg;
  logic [3:0]      edge_cnt_reg;
  logic [TW-1:0]   timer_reg;
  logic            clk_prev_reg;

  logic [1:0]      pin_raw;
  logic [1:0]      pin_sync;
  logic            clk_s;
  logic            data_s;
  logic            fall;
  logic            timeout;
  logic [3:0]      edge_inc;

  assign pin_raw = {ps2_data_in, ps2_clk_in};

  // Sync flops reset high so the idle bus does not look like a falling edge.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_reg <= 1'b1;
          s2_reg <= 1'b1;
        end else begin
          s1_reg <= pin_raw[gi];
          s2_reg <= s1_reg;
        end
      end
      assign pin_sync[gi] = s2_reg;
    end
  endgenerate

  assign clk_s  = pin_sync[0];
  assign data_s = pin_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_prev_reg <= 1'b1;
    end else begin
      clk_prev_reg <= clk_s;
    end
  end

  assign fall     = clk_prev_reg & ~clk_s;
  assign timeout  = (timer_reg == TIMEOUT_LAST);
  assign edge_inc = (edge_cnt_reg >= EDGE_MAX) ? EDGE_MAX : edge_cnt_reg + 4'd1;

  assign tx_ready = (state_reg == S_IDLE);
  assign tx_busy  = ~tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      sh_reg       <= '0;
      edge_cnt_reg <= '0;
      timer_reg    <= '0;
      ps2_clk_oe   <= 1'b0;
      ps2_data_oe  <= 1'b0;
      tx_done      <= 1'b0;
      tx_err       <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;

      // The timer saturates instead of wrapping; states that need a fresh
      // count clear it explicitly below.
      if (state_reg != S_IDLE && timer_reg != '1) begin
        timer_reg <= timer_reg + 1'b1;
      end

      case (state_reg)
        S_IDLE: begin
          if (tx_valid) begin
            sh_reg       <= {1'b1, ~^tx_data, tx_data};
            edge_cnt_reg <= '0;
            timer_reg    <= '0;
            ps2_clk_oe   <= 1'b1;
            ps2_data_oe  <= 1'b0;
            state_reg    <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (timer_reg == INHIBIT_LAST) begin
            ps2_data_oe <= 1'b1;
            timer_reg   <= '0;
            state_reg   <= S_REQ;
          end
        end

        S_REQ: begin
          ps2_clk_oe <= 1'b0;
          state_reg  <= S_SEND;
        end

        S_SEND: begin
          if (timeout) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_err      <= 1'b1;
            state_reg   <= S_IDLE;
          end else if (fall) begin
            // Pin is open-drain: pulling low sends a 0.
            ps2_data_oe  <= ~sh_reg[edge_cnt_reg];
            edge_cnt_reg <= edge_inc;
            if (edge_cnt_reg == 4'd9) begin
              state_reg <= S_ACK;
            end
          end
        end

        S_ACK: begin
          if (timeout) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_err      <= 1'b1;
            state_reg   <= S_IDLE;
          end else if (fall) begin
            edge_cnt_reg <= edge_inc;
            ps2_data_oe  <= 1'b0;
            if (!data_s) begin
              state_reg <= S_WAIT_IDLE;
            end else begin
              tx_err    <= 1'b1;
              state_reg <= S_IDLE;
            end
          end
        end

        S_WAIT_IDLE: begin
          if (timeout) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_err      <= 1'b1;
            state_reg   <= S_IDLE;
          end else if (clk_s && data_s) begin
            tx_done   <= 1'b1;
            state_reg <= S_IDLE;
          end
        end

        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          state_reg   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on an
// open-drain bus (40-cycle device clock period).
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  int errors = 0;
  int checks = 0;

  int   done_cnt = 0;
  int   err_cnt  = 0;
  int   both_cnt = 0;
  logic prev_err = 1'b0;
  logic ready_after_err = 1'b0;
  logic oe_at_err = 1'b1;

  always #5 clk = ~clk;

  assign ps2_clk_in  = ~(ps2_clk_oe  | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .TIMEOUT_CYCLES(5000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  // Pulse monitor: counts done/err pulses and captures state around err.
  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    if (tx_err === 1'b1) begin
      err_cnt   <= err_cnt + 1;
      oe_at_err <= ps2_clk_oe | ps2_data_oe;
    end
    if (tx_done === 1'b1 && tx_err === 1'b1) both_cnt <= both_cnt + 1;
    prev_err <= tx_err;
    if (prev_err === 1'b1) ready_after_err <= tx_ready;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic measure(output int inh, output int req);
    inh = 0;
    req = 0;
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && inh < 100) begin
      inh++;
      tick();
    end
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1 && req < 10) begin
      req++;
      tick();
    end
  endtask

  // Device model: waits for the start bit, then generates n_clocks clock
  // pulses, sampling the data pin at the end of each low phase. If
  // n_clocks < 11 it returns mid low phase of the last pulse.
  task automatic device(input logic ack_low, input int inject_at, input int n_clocks,
                        output logic [7:0] rbyte, output logic rpar, output logic rstop,
                        output logic started);
    logic [10:0] bits;
    int n;
    bits = '0;
    n = 0;
    while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && n < 200) begin
      tick();
      n++;
    end
    started = (n < 200);
    if (started) begin
      repeat (5) tick();
      for (int k = 1; k <= n_clocks; k++) begin
        if (k == 11 && ack_low) begin
          dev_data_low = 1'b1;
          repeat (2) tick();
        end
        dev_clk_low = 1'b1;
        repeat (10) tick();
        if (k == n_clocks && k < 11) break;
        if (k == inject_at) begin
          tx_data  = 8'h55;
          tx_valid = 1'b1;
          tick();
          tx_valid = 1'b0;
        end else begin
          tick();
        end
        repeat (8) tick();
        bits[k-1] = ps2_data_in;
        tick();
        dev_clk_low = 1'b0;
        repeat (20) tick();
        if (k == 11) dev_data_low = 1'b0;
      end
    end
    rbyte = bits[7:0];
    rpar  = bits[8];
    rstop = bits[9];
  endtask

  task automatic run_byte(input string tag, input logic [7:0] d, input logic ack_low,
                          input int inject_at, input logic [7:0] exp_byte, input logic exp_par,
                          input int exp_done, input int exp_err);
    int inh, req, d0, e0;
    logic [7:0] rbyte;
    logic rpar, rstop, started;
    d0 = done_cnt;
    e0 = err_cnt;
    send(d);
    measure(inh, req);
    check({tag, "_inhibit_len"}, inh, 20);
    check({tag, "_req_len"}, req, 1);
    device(ack_low, inject_at, 11, rbyte, rpar, rstop, started);
    check({tag, "_start_seen"}, started, 1);
    check({tag, "_byte"}, rbyte, exp_byte);
    check({tag, "_parity"}, rpar, exp_par);
    check({tag, "_stop"}, rstop, 1);
    repeat (10) tick();
    check({tag, "_done_pulses"}, done_cnt - d0, exp_done);
    check({tag, "_err_pulses"}, err_cnt - e0, exp_err);
    check({tag, "_ready"}, tx_ready, 1);
    check({tag, "_oe_idle"}, {ps2_clk_oe, ps2_data_oe}, 2'b00);
    $display("txn %s: sent=%02h rx=%02h par=%0d stop=%0d", tag, d, rbyte, rpar, rstop);
  endtask

  initial begin
    int inh, req, n, d0, e0;
    logic [7:0] rbyte;
    logic rpar, rstop, started;

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) tick();
    check("rst_ready", tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("rst_pulses", {tx_done, tx_err}, 2'b00);
    rst = 1'b0;
    tick();

    // 1: 0xED with ACK
    run_byte("s1_ED", 8'hED, 1'b1, 0, 8'hED, 1'b1, 1, 0);

    // 2: parity 0 and parity 1 bytes
    run_byte("s2_01", 8'h01, 1'b1, 0, 8'h01, 1'b0, 1, 0);
    run_byte("s2_FF", 8'hFF, 1'b1, 0, 8'hFF, 1'b1, 1, 0);

    // 3: NACK at fall 11
    run_byte("s3_nack", 8'h3C, 1'b0, 0, 8'h3C, 1'b1, 0, 1);
    check("s3_oe_at_err", oe_at_err, 0);
    check("s3_ready_after_err", ready_after_err, 1);

    // 4: device never clocks -> timeout 5000 cycles after REQ
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hA5);
    measure(inh, req);
    check("s4_req_len", req, 1);
    n = 1;
    while (tx_err !== 1'b1 && n < 6000) begin
      tick();
      n++;
    end
    check("s4_timeout_cycles", n, 5000);
    check("s4_oe_at_err", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    tick();
    check("s4_err_pulses", err_cnt - e0, 1);
    check("s4_done_pulses", done_cnt - d0, 0);
    check("s4_ready", tx_ready, 1);
    $display("txn s4_timeout: err after %0d cycles", n);

    // 5: tx_valid during SEND is ignored; back-to-back send afterwards
    run_byte("s5_AA", 8'hAA, 1'b1, 3, 8'hAA, 1'b1, 1, 0);
    run_byte("s5_55", 8'h55, 1'b1, 0, 8'h55, 1'b1, 1, 0);

    // 6: reset mid-transfer after fall 4
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h00);
    measure(inh, req);
    device(1'b1, 0, 4, rbyte, rpar, rstop, started);
    check("s6_pre_rst_data_oe", ps2_data_oe, 1);
    rst = 1'b1;
    #1;
    check("s6_rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("s6_rst_ready", tx_ready, 1);
    dev_clk_low = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    check("s6_no_done", done_cnt - d0, 0);
    check("s6_no_err", err_cnt - e0, 0);
    $display("txn s6_reset: aborted after fall 4");
    run_byte("s6_F4", 8'hF4, 1'b1, 0, 8'hF4, 1'b0, 1, 0);

    check("never_done_and_err", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
